updown_counter_param: RTL and testbench

Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable and a wrap-or-saturate mode. It generalises the fixed 4-bit down counter into a reusable block for timers, dividers and event counters. It flags the terminal count and emits a one-cycle pulse on every wrap or saturation hit, so downstream logic can cascade counters or gate events.

---
 rtl/updown_counter_param.sv | 124 ++++++++++++
 tb/tb_updown_counter_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// ---------------------------------------------------------------------------
// updown_counter_param
//
// Purpose:
//   Reusable up/down counter with a programmable modulus, parallel load,
//   count enable and a choice of wrapping or saturating at the bounds.
//   The count always stays in 0..MODULUS-1. A combinational terminal flag
//   and a registered one-cycle wrap pulse let downstream logic cascade
//   counters or gate events.
//
// Parameters:
//   WIDTH       - counter width in bits (1..32)
//   MODULUS     - count range is 0..MODULUS-1 (2..2^WIDTH)
//   SATURATE    - 0: wrap at the bounds, 1: hold at the bounds
//   RESET_VALUE - count value after reset (< MODULUS)
//
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   enable     in   1      count enable; count holds when low
//   up_down    in   1      direction: 1 = up, 0 = down
//   load       in   1      synchronous parallel load (beats enable)
//   load_value in   WIDTH  value loaded when load=1 (clamped to MODULUS-1)
//   count      out  WIDTH  current count, registered
//   terminal   out  1      count is at the bound in the current direction
//   wrap_pulse out  1      one-cycle pulse aligned with the count produced
//                          by a wrap, or by a step attempted past a bound
// ---------------------------------------------------------------------------
module updown_counter_param #(
  parameter int              WIDTH       = 4,
  parameter longint unsigned MODULUS     = 16,
  parameter bit              SATURATE    = 1'b0,
  parameter longint unsigned RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             wrap_pulse
);

  // Parameters are held as 64-bit values so MODULUS = 2^32 is representable
  // when WIDTH = 32; everything that touches the datapath is narrowed here.
  localparam longint unsigned COUNT_SPAN  = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  // Reject parameter combinations that would let count leave its range.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be in 1..32");
  end
  if (MODULUS < 64'd2 || MODULUS > COUNT_SPAN) begin : g_bad_modulus
    $error("updown_counter_param: MODULUS must be in 2..2^WIDTH");
  end
  if (RESET_VALUE >= MODULUS) begin : g_bad_reset_value
    $error("updown_counter_param: RESET_VALUE must be below MODULUS");
  end

  logic             at_max;
  logic             at_min;
  logic             load_in_range;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  // Bound detection uses explicit compares against MODULUS-1 and 0 rather
  // than relying on natural overflow, so non-power-of-two moduli work.
  // The load compare is done at 64 bits so a full-range modulus never
  // clamps a legal value.
  always_comb begin
    at_max        = (count == MAX_COUNT);
    at_min        = (count == '0);
    load_in_range = (64'(load_value) < MODULUS);
  end

  // terminal tracks up_down combinationally, so a direction change is
  // visible immediately even while the counter is disabled.
  always_comb begin
    terminal = up_down ? at_max : at_min;
  end

  // Next-state selection: load beats enable, enable beats hold. The wrap
  // flag is raised whenever an enabled step hits a bound, whether the
  // counter then wraps or saturates.
  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (load) begin
      next_count = load_in_range ? load_value : MAX_COUNT;
    end else if (enable) begin
      if (up_down) begin
        if (at_max) begin
          next_wrap  = 1'b1;
          next_count = SATURATE ? count : '0;
        end else begin
          next_count = count + ONE;
        end
      end else begin
        if (at_min) begin
          next_wrap  = 1'b1;
          next_count = SATURATE ? count : MAX_COUNT;
        end else begin
          next_count = count - ONE;
        end
      end
    end
  end

  // State register; reset takes effect immediately without a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= RESET_COUNT;
      wrap_pulse <= 1'b0;
    end else begin
      count      <= next_count;
      wrap_pulse <= next_wrap;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_param
//
// Purpose:
//   Directed bench for updown_counter_param. Two instances share clock and
//   reset: dut_wrap (MODULUS=10, wrap, reset to 0) and dut_sat (MODULUS=10,
//   saturate, reset to 3). Each has its own control inputs. Expected values
//   are written out by hand in the stimulus below.
// ---------------------------------------------------------------------------
module tb_updown_counter_param;

  logic       clock;
  logic       reset;

  logic       w_enable, w_up_down, w_load;
  logic [3:0] w_load_value;
  logic [3:0] w_count;
  logic       w_terminal, w_wrap_pulse;

  logic       s_enable, s_up_down, s_load;
  logic [3:0] s_load_value;
  logic [3:0] s_count;
  logic       s_terminal, s_wrap_pulse;

  int testsRun;
  int testsFailed;
  int wrapSeen;

  updown_counter_param #(
    .WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VALUE(0)
  ) dut_wrap (
    .clock(clock), .reset(reset),
    .enable(w_enable), .up_down(w_up_down), .load(w_load),
    .load_value(w_load_value),
    .count(w_count), .terminal(w_terminal), .wrap_pulse(w_wrap_pulse)
  );

  updown_counter_param #(
    .WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RESET_VALUE(3)
  ) dut_sat (
    .clock(clock), .reset(reset),
    .enable(s_enable), .up_down(s_up_down), .load(s_load),
    .load_value(s_load_value),
    .count(s_count), .terminal(s_terminal), .wrap_pulse(s_wrap_pulse)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and land 1 ns after it for sampling/driving.
  task automatic applyStimulus;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int expDown[11];
    int expUp[12];
    expDown = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
    expUp   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    testsRun    = 0;
    testsFailed = 0;
    wrapSeen    = 0;

    reset = 1'b1;
    w_enable = 1'b0; w_up_down = 1'b0; w_load = 1'b0; w_load_value = 4'd0;
    s_enable = 1'b0; s_up_down = 1'b0; s_load = 1'b0; s_load_value = 4'd0;

    // Reset state, sampled while reset is still held.
    #12;
    checkOutput("reset_w_count", w_count, 0);
    checkOutput("reset_w_wrap", w_wrap_pulse, 0);
    checkOutput("reset_w_terminal", w_terminal, 1);
    checkOutput("reset_s_count", s_count, 3);
    checkOutput("reset_s_wrap", s_wrap_pulse, 0);

    // Release at t=22; first update on the edge at t=25.
    #10;
    reset = 1'b0;
    w_enable = 1'b1;
    w_up_down = 1'b0;

    // Wrapping down count: 9,8,...,1,0,9 with pulses on each 9.
    for (int i = 0; i < 11; i++) begin
      applyStimulus();
      checkOutput($sformatf("down_count_%0d", i), w_count, expDown[i]);
      checkOutput($sformatf("down_wrap_%0d", i), w_wrap_pulse, (expDown[i] == 9) ? 1 : 0);
      checkOutput($sformatf("down_terminal_%0d", i), w_terminal, (expDown[i] == 0) ? 1 : 0);
    end

    // Load 0 to start the up run from a known value.
    w_load = 1'b1; w_load_value = 4'd0;
    applyStimulus();
    w_load = 1'b0;
    checkOutput("load0_count", w_count, 0);
    checkOutput("load0_wrap", w_wrap_pulse, 0);

    // Wrapping up count: 1..9,0,1,2 with a single pulse on the 0.
    w_up_down = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      checkOutput($sformatf("up_count_%0d", i), w_count, expUp[i]);
      checkOutput($sformatf("up_wrap_%0d", i), w_wrap_pulse, (i == 9) ? 1 : 0);
      checkOutput($sformatf("up_terminal_%0d", i), w_terminal, (expUp[i] == 9) ? 1 : 0);
      if (w_wrap_pulse === 1'b1) wrapSeen++;
    end
    checkOutput("up_wrap_once", wrapSeen, 1);

    // Load beats enable/up in the same cycle.
    w_load = 1'b1; w_load_value = 4'd5;
    applyStimulus();
    checkOutput("load_prec_count", w_count, 5);
    checkOutput("load_prec_wrap", w_wrap_pulse, 0);

    // Out-of-range load value is clamped to MODULUS-1.
    w_load_value = 4'd12;
    applyStimulus();
    checkOutput("load_clamp_count", w_count, 9);

    // Load 3 then hold with enable low for 5 edges.
    w_load_value = 4'd3;
    applyStimulus();
    w_load = 1'b0;
    w_enable = 1'b0;
    checkOutput("load3_count", w_count, 3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput($sformatf("hold_count_%0d", i), w_count, 3);
      checkOutput($sformatf("hold_wrap_%0d", i), w_wrap_pulse, 0);
    end

    // At count 0 with enable low, up_down only moves terminal.
    w_load = 1'b1; w_load_value = 4'd0;
    applyStimulus();
    w_load = 1'b0;
    w_up_down = 1'b0;
    #1;
    checkOutput("dirtog_term_down", w_terminal, 1);
    w_up_down = 1'b1;
    #1;
    checkOutput("dirtog_term_up", w_terminal, 0);
    applyStimulus();
    checkOutput("dirtog_count", w_count, 0);

    // Saturating instance: load 8, then up four times -> 9,9,9,9.
    s_load = 1'b1; s_load_value = 4'd8;
    applyStimulus();
    s_load = 1'b0;
    checkOutput("sat_load8", s_count, 8);
    s_enable = 1'b1; s_up_down = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput($sformatf("sat_up_count_%0d", i), s_count, 9);
      checkOutput($sformatf("sat_up_wrap_%0d", i), s_wrap_pulse, (i == 0) ? 0 : 1);
    end
    checkOutput("sat_terminal_up", s_terminal, 1);
    s_up_down = 1'b0;
    applyStimulus();
    checkOutput("sat_down_count", s_count, 8);
    checkOutput("sat_down_wrap", s_wrap_pulse, 0);

    // Saturating at the lower bound holds 0 and pulses.
    s_load = 1'b1; s_load_value = 4'd0;
    applyStimulus();
    s_load = 1'b0;
    applyStimulus();
    checkOutput("sat_low_count", s_count, 0);
    checkOutput("sat_low_wrap", s_wrap_pulse, 1);
    s_enable = 1'b0;
    applyStimulus();
    checkOutput("sat_idle_wrap", s_wrap_pulse, 0);

    // Asynchronous reset mid-cycle at count 7.
    w_load = 1'b1; w_load_value = 4'd7;
    s_load = 1'b1; s_load_value = 4'd7;
    applyStimulus();
    w_load = 1'b0; s_load = 1'b0;
    w_enable = 1'b0; w_up_down = 1'b1;
    checkOutput("pre_reset_count", w_count, 7);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_w_count", w_count, 0);
    checkOutput("async_s_count", s_count, 3);
    checkOutput("async_w_wrap", w_wrap_pulse, 0);
    #2;
    reset = 1'b0;
    w_enable = 1'b1;
    s_enable = 1'b1; s_up_down = 1'b1;
    applyStimulus();
    checkOutput("resume_w_count", w_count, 1);
    checkOutput("resume_s_count", s_count, 4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
